jt51_timer_ctrl: RTL
====================

# jt51_timer_ctrl

CPU-side register front end for the JT51 timer pair. It decodes the YM2151 two-port bus (address port, data port), holds the timer registers (0x10, 0x11, 0x12, 0x14), and drives the timer block's control inputs: start values, load levels, IRQ enables and flag-clear pulses. It returns the status byte (busy, flag B, flag A) on reads. It sits between the host bus and the timer block and consumes that block's flag outputs.

## Interface
- `BUSY_CYC`, default 32: number of `cen` cycles the busy bit stays set after a data-port write.
- `rst`  in  1  asynchronous active-high reset
- `clk`  in  1  system clock
- `cen`  in  1  clock enable; paces only the busy counter
- `cs_n`  in  1  chip select, active low
- `wr_n`  in  1  write strobe, active low
- `a0`  in  1  port select: 0 = address, 1 = data
- `din`  in  8  write data
- `dout`  out  8  status byte, registered
- `flag_A`, `flag_B`  in  1 each  timer flags from the timer block
- `value_A`  out  10  timer A start value
- `value_B`  out  8  timer B start value
- `load_A`, `load_B`  out  1 each  run levels (reg 0x14 bits 0 and 1)
- `enable_irq_A`, `enable_irq_B`  out  1 each  reg 0x14 bits 2 and 3
- `clr_flag_A`, `clr_flag_B`  out  1 each  one-clk clear pulses (reg 0x14 bits 4 and 5)
- `csm`  out  1  reg 0x14 bit 7
- `busy`  out  1  busy status

## Operation
- **Write event**
  - Registered on the first `clk` edge where `cs_n`=0 and `wr_n`=0 while the previous sample of (`cs_n`|`wr_n`) was 1.
  - A held strobe produces exactly one event.
- **Address write** (`a0`=0): latches `din` into the 8-bit address register. Busy is unaffected.
- **Data write** (`a0`=1): `din` goes to the latched address.
  - 0x10: `value_A[9:2]` <= `din`.
  - 0x11: `value_A[1:0]` <= `din[1:0]`.
  - 0x12: `value_B` <= `din`.
  - 0x14: `load_A`=`din[0]`, `load_B`=`din[1]`, `enable_irq_A`=`din[2]`, `enable_irq_B`=`din[3]`, `csm`=`din[7]`. `din[4]`/`din[5]` fire `clr_flag_A`/`clr_flag_B` for exactly one `clk`, in the cycle after the event. `din[6]` is ignored.
  - Any other address: no register change.
- **Busy** (applies to every data write, decoded or not)
  - The write sets the busy counter to `BUSY_CYC`; `busy`=1 while the counter is non-zero.
  - The counter decrements on `clk` edges with `cen`=1.
  - A data write while busy is still accepted and reloads the counter to `BUSY_CYC`.
- **Status**
  - `dout` <= {`busy`, 5'b0, `flag_B`, `flag_A`} every `clk`.
  - Both ports read the same value; reads have no side effects.
- **Load levels**: `load_A`/`load_B` are held levels. The timer block restarts a counter on its rising edge, so rewriting 1 over 1 does not restart it.

## Timing
- **Reset**: every output is 0, the address register is 0, the busy counter is 0, and the strobe history is 1.
- **Latency**
  - Register outputs update on the edge that registers the event, so they are visible in the next cycle.
  - The clear pulse is high during the cycle after the event.
  - `busy` rises on the event edge.
  - `dout` lags its sources by one `clk`.
- **Busy duration**: `busy` falls on the `BUSY_CYC`-th `cen`-qualified edge after the event. A `cen` coincident with the event edge does not count.
- **Simultaneous events**
  - A 0x14 write with bit 4=1 while `flag_A` is being set: the clear pulse still issues. The timer block gives clear priority.
  - Address and data events cannot coincide (single strobe).
- **Reset mid-operation**: asynchronous.
  - A pending clear pulse is dropped.
  - `busy` clears immediately.
  - A strobe still held low after reset release does not produce an event.
- **Arithmetic**: the busy counter is `$clog2(BUSY_CYC+1)` bits and saturates at 0.

## Test plan
- **Timer A value**: addr 0x10, data 0xA5; addr 0x11, data 0xFE → `value_A`=10'h296; `busy`=1 for 32 `cen` cycles after each data write, then 0.
- **Control register**: addr 0x14, data 0x3F → `load_A`=`load_B`=`enable_irq_A`=`enable_irq_B`=1; `clr_flag_A` and `clr_flag_B` each high for exactly one `clk`; `csm`=0.
- **Status read**: `flag_A`=1, `flag_B`=0, not busy → `dout`=0x01 one `clk` later. Busy with both flags set → `dout`=0x83.
- **Strobe and undecoded address**: `wr_n` held low for 10 `clk`s with `a0`=1 → one write only; `busy` reloads once. A data write to addr 0x20 → no output changes, `busy`=1.
- **Busy reload**: a second data write 5 `cen`s into busy → `busy` stays high for 32 `cen`s from the second write.
- **Reset mid-operation**: assert `rst` while busy and while a clear pulse is pending → all outputs 0 immediately. No event fires after release with `wr_n` still low.

Source files
------------

// File: rtl/jt51_timer_ctrl.sv
// Host-bus register front end for the JT51 timer pair: decodes the two-port
// bus, holds timer registers 0x10/0x11/0x12/0x14 and returns the status byte.
module jt51_timer_ctrl #(
    parameter int BUSY_CYC = 32
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       csm,
    output logic       busy
);

    localparam int CW = $clog2(BUSY_CYC + 1);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYC);

    logic [7:0]    addr;
    logic [CW-1:0] busy_cnt;
    logic          strobe_prev;
    logic          armed;
    logic          strobe_idle;
    logic          wr_event;
    logic          data_wr;

    // armed stays low until the strobe has been seen idle after reset, so a
    // strobe still held low across reset release never produces an event.
    assign strobe_idle = cs_n | wr_n;
    assign wr_event    = ~strobe_idle & strobe_prev & armed;
    assign data_wr     = wr_event & a0;
    assign busy        = (busy_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_prev  <= 1'b1;
            armed        <= 1'b0;
            addr         <= 8'h00;
            value_A      <= 10'h000;
            value_B      <= 8'h00;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
            csm          <= 1'b0;
        end else begin
            strobe_prev <= strobe_idle;
            if (strobe_idle) begin
                armed <= 1'b1;
            end
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (wr_event && !a0) begin
                addr <= din;
            end
            if (data_wr) begin
                case (addr)
                    8'h10: value_A[9:2] <= din;
                    8'h11: value_A[1:0] <= din[1:0];
                    8'h12: value_B      <= din;
                    8'h14: begin
                        load_A       <= din[0];
                        load_B       <= din[1];
                        enable_irq_A <= din[2];
                        enable_irq_B <= din[3];
                        clr_flag_A   <= din[4];
                        clr_flag_B   <= din[5];
                        csm          <= din[7];
                    end
                    default: ;
                endcase
            end
        end
    end

    // A data write reloads the counter even if a cen arrives on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (data_wr) begin
            busy_cnt <= BUSY_LOAD;
        end else if (cen && busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 8'h00;
        end else begin
            dout <= {busy, 5'b00000, flag_B, flag_A};
        end
    end

endmodule
